// File: rtl/mem_block_mover.sv
// Front-end for the 256x8 data memory: CPU pass-through when idle, and a byte-wise
// ascending block copy (src, dst, len) that stalls the CPU while it runs.
module mem_block_mover (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cpu_addr,
    input  logic       cpu_mem_read,
    input  logic       cpu_mem_write,
    input  logic [7:0] cpu_data_in,
    output logic [7:0] cpu_data_out,
    output logic       cpu_stall,
    input  logic       start,
    input  logic [7:0] src,
    input  logic [7:0] dst,
    input  logic [7:0] len,
    output logic       busy,
    output logic       done,
    output logic [7:0] mem_addr,
    output logic       mem_read,
    output logic       mem_write,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] src_q;
    logic [7:0] dst_q;
    logic [7:0] cnt;
    logic [7:0] byte_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (len != 8'd0) ? RD : DONE;
            RD:      state_next = WR;
            WR:      state_next = (cnt == 8'd1) ? DONE : RD;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Copy datapath: pointers advance and the count drops once per committed byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q  <= 8'd0;
            dst_q  <= 8'd0;
            cnt    <= 8'd0;
            byte_q <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q <= src;
                        dst_q <= dst;
                        cnt   <= len;
                    end
                end
                RD: byte_q <= mem_rdata;
                WR: begin
                    src_q <= src_q + 8'd1;
                    dst_q <= dst_q + 8'd1;
                    cnt   <= cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Reset forces the memory port quiet; IDLE and DONE both pass CPU traffic through.
    always_comb begin
        mem_addr     = cpu_addr;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_wdata    = cpu_data_in;
        cpu_data_out = 8'h00;
        busy         = 1'b0;
        done         = 1'b0;
        if (!reset) begin
            case (state)
                IDLE, DONE: begin
                    mem_read     = cpu_mem_read;
                    mem_write    = cpu_mem_write;
                    cpu_data_out = cpu_mem_read ? mem_rdata : 8'h00;
                    done         = (state == DONE);
                end
                RD: begin
                    mem_addr = src_q;
                    mem_read = 1'b1;
                    busy     = 1'b1;
                end
                WR: begin
                    mem_addr  = dst_q;
                    mem_write = 1'b1;
                    mem_wdata = byte_q;
                    busy      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cpu_stall = busy;

endmodule

// File: tb/tb_mem_block_mover.sv
// Bench for mem_block_mover: a 256x8 memory behind the DUT plus a reference array
// updated with plain copy-loop semantics, compared after every scenario.
module tb_mem_block_mover;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cpu_addr;
    logic       cpu_mem_read;
    logic       cpu_mem_write;
    logic [7:0] cpu_data_in;
    logic [7:0] cpu_data_out;
    logic       cpu_stall;
    logic       start;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    logic       busy;
    logic       done;
    logic [7:0] mem_addr;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic [7:0] mem   [256];
    logic [7:0] model [256];
    logic       bd_we;
    logic [7:0] bd_addr;
    logic [7:0] bd_data;

    int total  = 0;
    int passed = 0;

    mem_block_mover dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
        .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out), .cpu_stall(cpu_stall),
        .start(start), .src(src), .dst(dst), .len(len), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write on posedge; backdoor port preloads it while idle.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        else if (bd_we) mem[bd_addr] <= bd_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d; model[a] = d;
        step();
        bd_we = 1'b0;
    endtask

    task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
        for (int k = 0; k < int'(l); k++) model[8'(int'(d) + k)] = model[8'(int'(s) + k)];
    endtask

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== model[i]) n++;
        return n;
    endfunction

    task automatic do_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                           output int done_cyc, output int busy_cnt, output int first_busy,
                           output int last_busy, output int done_cnt);
        src = s; dst = d; len = l; start = 1'b1;
        done_cyc = -1; busy_cnt = 0; first_busy = -1; last_busy = -1; done_cnt = 0;
        step();
        start = 1'b0;
        for (int c = 1; c <= 600; c++) begin
            if (busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = c;
                last_busy = c;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_addr = 8'h33; cpu_data_in = 8'hC3;
        cpu_mem_read = 1'b1; cpu_mem_write = 1'b1;
        step(); step();
        total++; if ({mem_read, mem_write} !== 2'b00) $display("[TB] FAIL reset_mem_rw: got %b expected 00", {mem_read, mem_write}); else passed++;
        total++; if (cpu_data_out !== 8'h00) $display("[TB] FAIL reset_cpu_data_out: got %h expected 00", cpu_data_out); else passed++;
        total++; if ({busy, done, cpu_stall} !== 3'b000) $display("[TB] FAIL reset_flags: got %b expected 000", {busy, done, cpu_stall}); else passed++;
        total++; if ({mem_addr, mem_wdata} !== 16'h33C3) $display("[TB] FAIL reset_follow_cpu: got %h expected 33c3", {mem_addr, mem_wdata}); else passed++;
        cpu_mem_read = 1'b0; cpu_mem_write = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_passthrough();
        logic [7:0] a;
        logic [7:0] d;
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom); d = 8'($urandom);
            cpu_addr = a; cpu_data_in = d; cpu_mem_write = 1'b1;
            #1;
            total++; if ({mem_write, mem_read, mem_addr, mem_wdata} !== {2'b10, a, d}) $display("[TB] FAIL pass_write: got %h expected %h", {mem_write, mem_read, mem_addr, mem_wdata}, {2'b10, a, d}); else passed++;
            step();
            model[a] = d;
            cpu_mem_write = 1'b0;
            cpu_addr = 8'($urandom); cpu_mem_read = 1'b1;
            #1;
            total++; if (cpu_data_out !== model[cpu_addr]) $display("[TB] FAIL pass_read: got %h expected %h", cpu_data_out, model[cpu_addr]); else passed++;
            cpu_mem_read = 1'b0;
            #1;
            total++; if ({mem_read, cpu_data_out} !== 9'h000) $display("[TB] FAIL pass_noread: got %h expected 000", {mem_read, cpu_data_out}); else passed++;
            step();
        end
        total++; if (mem_diffs() !== 0) $display("[TB] FAIL pass_memory: got %0d diffs expected 0", mem_diffs()); else passed++;
    endtask

    task automatic test_basic();
        int dc, bc, fb, lb, nd;
        poke(8'd10, 8'h11); poke(8'd11, 8'h22); poke(8'd12, 8'h33); poke(8'd13, 8'h44);
        model_copy(8'd10, 8'd50, 8'd4);
        do_copy(8'd10, 8'd50, 8'd4, dc, bc, fb, lb, nd);
        total++; if (dc !== 9) $display("[TB] FAIL basic_done_cycle: got %0d expected 9", dc); else passed++;
        total++; if ({fb, lb, bc} !== {32'd1, 32'd8, 32'd8}) $display("[TB] FAIL basic_busy_window: got first %0d last %0d count %0d expected 1 8 8", fb, lb, bc); else passed++;
        total++; if (nd !== 1) $display("[TB] FAIL basic_done_count: got %0d expected 1", nd); else passed++;
        total++; if ({mem[50], mem[51], mem[52], mem[53]} !== 32'h11223344) $display("[TB] FAIL basic_dest: got %h expected 11223344", {mem[50], mem[51], mem[52], mem[53]}); else passed++;
        total++; if (mem_diffs() !== 0) $display("[TB] FAIL basic_memory: got %0d diffs expected 0", mem_diffs()); else passed++;
    endtask

    task automatic test_len0();
        int dc, bc, fb, lb, nd;
        poke(8'd6, 8'h7F);
        do_copy(8'd5, 8'd6, 8'd0, dc, bc, fb, lb, nd);
        total++; if (dc !== 1) $display("[TB] FAIL len0_done_cycle: got %0d expected 1", dc); else passed++;
        total++; if (bc !== 0) $display("[TB] FAIL len0_busy: got %0d busy cycles expected 0", bc); else passed++;
        total++; if (mem[6] !== 8'h7F) $display("[TB] FAIL len0_memory: got %h expected 7f", mem[6]); else passed++;
    endtask

    task automatic test_overlap();
        int dc, bc, fb, lb, nd;
        poke(8'd20, 8'hAA); poke(8'd21, 8'hBB);
        model_copy(8'd20, 8'd21, 8'd3);
        do_copy(8'd20, 8'd21, 8'd3, dc, bc, fb, lb, nd);
        total++; if ({mem[21], mem[22], mem[23]} !== 24'hAAAAAA) $display("[TB] FAIL overlap_dest: got %h expected aaaaaa", {mem[21], mem[22], mem[23]}); else passed++;
        total++; if (dc !== 7) $display("[TB] FAIL overlap_done_cycle: got %0d expected 7", dc); else passed++;
        total++; if (mem_diffs() !== 0) $display("[TB] FAIL overlap_memory: got %0d diffs expected 0", mem_diffs()); else passed++;
    endtask

    task automatic test_wrap();
        int dc, bc, fb, lb, nd;
        poke(8'hFE, 8'h01); poke(8'hFF, 8'h02); poke(8'h00, 8'h03);
        model_copy(8'hFE, 8'h80, 8'd3);
        do_copy(8'hFE, 8'h80, 8'd3, dc, bc, fb, lb, nd);
        total++; if ({mem[8'h80], mem[8'h81], mem[8'h82]} !== 24'h010203) $display("[TB] FAIL wrap_src: got %h expected 010203", {mem[8'h80], mem[8'h81], mem[8'h82]}); else passed++;
        model_copy(8'h80, 8'hFF, 8'd2);
        do_copy(8'h80, 8'hFF, 8'd2, dc, bc, fb, lb, nd);
        total++; if ({mem[8'hFF], mem[8'h00]} !== 16'h0102) $display("[TB] FAIL wrap_dst: got %h expected 0102", {mem[8'hFF], mem[8'h00]}); else passed++;
        total++; if (mem_diffs() !== 0) $display("[TB] FAIL wrap_memory: got %0d diffs expected 0", mem_diffs()); else passed++;
    endtask

    task automatic test_stall();
        int nd, dc;
        poke(8'h90, 8'h3C);
        for (int i = 0; i < 4; i++) poke(8'(10 + i), 8'($urandom));
        model_copy(8'd10, 8'd50, 8'd4);
        src = 8'd10; dst = 8'd50; len = 8'd4; start = 1'b1;
        step();
        start = 1'b0;
        step();
        cpu_addr = 8'h90; cpu_data_in = 8'h5A; cpu_mem_write = 1'b1;
        start = 1'b1; src = 8'd0; dst = 8'h90; len = 8'd1;
        #1;
        total++; if (cpu_stall !== 1'b1) $display("[TB] FAIL stall_flag: got %b expected 1", cpu_stall); else passed++;
        total++; if ({mem_write, mem_read, mem_addr} !== {2'b10, 8'd50}) $display("[TB] FAIL stall_port_wr: got %h expected %h", {mem_write, mem_read, mem_addr}, {2'b10, 8'd50}); else passed++;
        step();
        cpu_mem_read = 1'b1;
        #1;
        total++; if ({cpu_data_out, mem_addr, mem_read} !== {8'h00, 8'd11, 1'b1}) $display("[TB] FAIL stall_port_rd: got %h expected %h", {cpu_data_out, mem_addr, mem_read}, {8'h00, 8'd11, 1'b1}); else passed++;
        step(); step();
        cpu_mem_read = 1'b0; cpu_mem_write = 1'b0; start = 1'b0;
        nd = 0; dc = -1;
        for (int c = 5; c <= 14; c++) begin
            if (done) begin
                nd++;
                if (dc < 0) dc = c;
            end
            step();
        end
        total++; if ({nd, dc} !== {32'd1, 32'd9}) $display("[TB] FAIL stall_done: got count %0d cycle %0d expected 1 9", nd, dc); else passed++;
        total++; if (mem[8'h90] !== 8'h3C) $display("[TB] FAIL stall_ignored_write: got %h expected 3c", mem[8'h90]); else passed++;
        total++; if (mem_diffs() !== 0) $display("[TB] FAIL stall_memory: got %0d diffs expected 0", mem_diffs()); else passed++;
        cpu_addr = 8'd50; cpu_mem_read = 1'b1;
        #1;
        total++; if (cpu_data_out !== model[50]) $display("[TB] FAIL stall_readback: got %h expected %h", cpu_data_out, model[50]); else passed++;
        cpu_mem_read = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        int dc, bc, fb, lb, nd;
        logic [7:0] l;
        src = 8'd100; dst = 8'd150; len = 8'd8; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 5; c++) step();
        reset = 1'b1;
        #1;
        total++; if ({mem_read, mem_write, cpu_data_out} !== 10'h000) $display("[TB] FAIL rstmid_quiet: got %h expected 000", {mem_read, mem_write, cpu_data_out}); else passed++;
        step();
        reset = 1'b0;
        #1;
        total++; if ({busy, done, cpu_stall} !== 3'b000) $display("[TB] FAIL rstmid_flags: got %b expected 000", {busy, done, cpu_stall}); else passed++;
        bc = 0; nd = 0;
        for (int c = 0; c < 10; c++) begin
            if (busy) bc++;
            if (done) nd++;
            step();
        end
        total++; if ({bc, nd} !== 64'd0) $display("[TB] FAIL rstmid_after: got busy %0d done %0d expected 0 0", bc, nd); else passed++;
        model_copy(8'd100, 8'd150, 8'd2);
        total++; if (mem_diffs() !== 0) $display("[TB] FAIL rstmid_memory: got %0d diffs expected 0", mem_diffs()); else passed++;
        l = 8'($urandom_range(1, 16));
        model_copy(8'd30, 8'd200, l);
        do_copy(8'd30, 8'd200, l, dc, bc, fb, lb, nd);
        total++; if ({dc, nd} !== {2 * int'(l) + 1, 32'd1}) $display("[TB] FAIL rstmid_restart: got cycle %0d count %0d expected %0d 1", dc, nd, 2 * int'(l) + 1); else passed++;
        total++; if (mem_diffs() !== 0) $display("[TB] FAIL rstmid_restart_memory: got %0d diffs expected 0", mem_diffs()); else passed++;
    endtask

    task automatic test_random();
        int dc, bc, fb, lb, nd;
        logic [7:0] s;
        logic [7:0] d;
        logic [7:0] l;
        for (int i = 0; i < 7; i++) begin
            s = 8'($urandom); d = 8'($urandom);
            l = (i == 6) ? 8'd255 : 8'($urandom_range(0, 24));
            model_copy(s, d, l);
            do_copy(s, d, l, dc, bc, fb, lb, nd);
            total++; if ({dc, bc, nd} !== {2 * int'(l) + 1, 2 * int'(l), 32'd1}) $display("[TB] FAIL random_timing: src %h dst %h len %0d got done %0d busy %0d count %0d expected %0d %0d 1", s, d, l, dc, bc, nd, 2 * int'(l) + 1, 2 * int'(l)); else passed++;
            total++; if (mem_diffs() !== 0) $display("[TB] FAIL random_memory: src %h dst %h len %0d got %0d diffs expected 0", s, d, l, mem_diffs()); else passed++;
        end
    endtask

    initial begin
        reset = 1'b1; cpu_addr = 8'h00; cpu_mem_read = 1'b0; cpu_mem_write = 1'b0;
        cpu_data_in = 8'h00; start = 1'b0; src = 8'h00; dst = 8'h00; len = 8'h00;
        bd_we = 1'b0; bd_addr = 8'h00; bd_data = 8'h00;
        test_reset();
        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
        test_passthrough();
        test_basic();
        test_len0();
        test_overlap();
        test_wrap();
        test_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_block_mover.md
# mem_block_mover

Front-end for the 256x8 data memory. It sits directly upstream of the data memory and owns its single address/read/write port. When idle it passes CPU load/store traffic straight through. On command it runs a byte-wise block copy (src, dst, len) inside data memory and stalls the CPU until the copy finishes.

## Interface
- SIZE, 256, data memory depth; all addresses are 8-bit and wrap mod 256
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- cpu_addr  in  8  CPU load/store address
- cpu_mem_read  in  1  CPU load request
- cpu_mem_write  in  1  CPU store request
- cpu_data_in  in  8  CPU store data
- cpu_data_out  out  8  CPU load data
- cpu_stall  out  1  CPU must hold its current access; equals busy
- start  in  1  copy command; sampled only in IDLE
- src  in  8  copy source base; captured with start
- dst  in  8  copy destination base; captured with start
- len  in  8  byte count; 0 means no-op
- busy  out  1  copy in progress
- done  out  1  single-cycle completion pulse
- mem_addr  out  8  to data memory addr
- mem_read  out  1  to data memory read enable
- mem_write  out  1  to data memory write enable
- mem_wdata  out  8  to data memory write data
- mem_rdata  in  8  from data memory read data; combinational, valid while mem_read=1

## Operation
- States: IDLE, RD, WR, DONE. Registers: src_q, dst_q, cnt (8-bit), byte_q (8-bit).
- IDLE: pass-through. mem_addr=cpu_addr, mem_read=cpu_mem_read, mem_write=cpu_mem_write, mem_wdata=cpu_data_in.
  - cpu_data_out = mem_rdata when cpu_mem_read=1, else 8'h00. Never Z.
- IDLE with start=1: capture src, dst, len into src_q, dst_q, cnt. Next state is RD if len!=0, else DONE.
  - The CPU access presented in the same cycle as start still completes, because pass-through is active in IDLE.
- RD: mem_addr=src_q, mem_read=1, mem_write=0. At posedge: byte_q<=mem_rdata, then go to WR.
- WR: mem_addr=dst_q, mem_write=1, mem_read=0, mem_wdata=byte_q. At posedge: src_q+=1, dst_q+=1 (mod 256), cnt-=1.
  - If the decremented cnt is 0, go to DONE; else go to RD.
- DONE: done=1 for one cycle with pass-through active, then go to IDLE unconditionally.
- RD and WR: busy=1 and cpu_stall=1. CPU requests are ignored and cpu_data_out=8'h00.
- start is ignored outside IDLE. It is not queued.
- Copy direction is always ascending.
  - Overlap with dst in (src, src+len) replicates the leading bytes. This is the defined behaviour, not an error.
- Address wrap: src_q/dst_q at 8'hFF increment to 8'h00.
- Reset (any state): state returns to IDLE and cnt=0; busy=0, done=0.
  - Bytes already written stay in memory. No done pulse is issued for an aborted copy.
  - While reset=1, mem_read=0, mem_write=0 and cpu_data_out=8'h00, regardless of CPU inputs.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- Byte k (0-based) is read in cycle 2k+1. It is written in cycle 2k+2 and commits at the end of that cycle.
- busy is high in cycles 1..2len. done is high in cycle 2len+1 with busy=0.
  - Total latency is 2len+1 cycles. The next start is accepted at cycle 2len+2.
- len=0: done in cycle 1, busy never asserts, and memory is untouched.
- Maximum copy is len=255, which takes 511 cycles.
- Reset values: busy=0, done=0, cpu_stall=0, mem_read=0, mem_write=0, cpu_data_out=8'h00. mem_addr and mem_wdata follow the CPU inputs.
- All mem_* outputs are combinational from the state and registers (plus CPU inputs in IDLE/DONE). No added latency to data memory.

## Test plan
- Basic copy: preload M[10..13]=11,22,33,44; start src=10 dst=50 len=4.
  - Required: M[50..53]=11,22,33,44; busy for cycles 1..8; done in cycle 9; M[10..13] unchanged.
- len=0: start src=5 dst=6 len=0 with M[6]=7F.
  - Required: done in cycle 1, busy never high, M[6]=7F.
- Overlap: M[20]=AA, M[21]=BB; start src=20 dst=21 len=3.
  - Required: M[21..23]=AA,AA,AA.
- Wrap-around: M[FE]=01, M[FF]=02, M[00]=03; start src=FE dst=80 len=3.
  - Required: M[80..82]=01,02,03. A copy with dst=FF len=2 writes M[FF] then M[00].
- Stall/ignore: mid-copy, drive a CPU write (addr=90, data=5A) and a second start.
  - Required: cpu_stall=1; M[90] unchanged; the second start is dropped; only one done pulse.
  - After done, a CPU read of addr=50 returns the copied byte on cpu_data_out in the same cycle.
- Reset mid-copy: start len=8 and assert reset in cycle 5.
  - Required: bytes 0..1 are written and bytes 2..7 untouched; busy=0 and done=0 from the next cycle.
  - A new start after reset completes normally.
